stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised, registered N-channel, W-bit stream selector: the handshaked, multi-channel successor to the 2-input 16-bit datapath mux.
- Each input channel uses valid/ready. One output register holds the selected word and its source channel.
- Two modes: external fixed select, or round-robin arbitration. Used between ALU/memory-mapped producers and a single downstream consumer in the Hack datapath.

Parameters:
- W, 16, data width per channel (≥1)
- N, 4, channel count (≥2)
- MODE, 0, 0 = fixed select via sel, 1 = round-robin
- SW, $clog2(N), select/channel-id width (derived, localparam)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  N*W  flattened channel data; channel k at [k*W +: W]
- in_valid  in  N  per-channel valid
- in_ready  out  N  per-channel ready, at most one bit set
- sel  in  SW  channel select, used only when MODE=0
- out_data  out  W  registered selected word
- out_chan  out  SW  registered source channel of out_data
- out_valid  out  1  output register holds a word
- out_ready  in  1  downstream accepts the word

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, out_chan=0, rr_ptr=0.
  - in_ready=0 while reset is asserted.
  - Reset mid-transfer discards the held word; no partial state survives.
- load = !out_valid || out_ready (combinational). The register is refilled in the same cycle it drains, so full throughput is 1 word/cycle.
- Grant (combinational, one-hot gnt[N-1:0]):
  - MODE=0: gnt[sel] = in_valid[sel]. If sel ≥ N, gnt=0 and no transfer occurs.
  - MODE=1: gnt is the first k in order rr_ptr, rr_ptr+1, …, N-1, 0, …, rr_ptr-1 with in_valid[k]=1. gnt=0 if no channel is valid.
- in_ready = gnt & {N{load}}. Transfer on channel k when in_valid[k] && in_ready[k].
- On a transfer from channel k, at the clock edge:
  - out_data ← channel k data
  - out_chan ← k
  - out_valid ← 1
  - MODE=1 only: rr_ptr ← (k+1) mod N, wrapping N-1 → 0
- No transfer and out_ready=1: out_valid ← 0. out_data and out_chan hold their values.
- No transfer and out_ready=0 with out_valid=1: everything holds (backpressure). in_ready stays all-zero.
- Latency: input handshake to out_valid is 1 cycle.
- Ordering:
  - No reordering within a channel.
  - MODE=1: no channel waits more than N-1 grants while continuously valid.
- rr_ptr changes only on a transfer. Idle cycles do not rotate priority.
- Simultaneous drain and fill in one cycle: the new word replaces the old; no bubble; out_valid stays 1.
- Changing sel while out_valid=1 and out_ready=0 has no effect until load=1.
- Ready may depend combinationally on in_valid. Valid must not depend on ready; producers obey this.
- Data is not modified: no width conversion, zero-extension or truncation.

Decomposition:
- Package stream_mux_pkg holds:
  - MODE_FIXED=0, MODE_RR=1
  - a helper function for channel-id width
- Sub-module rr_arbiter (N):
  - Inputs: req[N], ptr[SW].
  - Output: one-hot gnt[N].
  - Purely combinational rotate / priority-encode / rotate-back.
  - Instantiated only when MODE=1.
- Top level holds the output register, rr_ptr register and fixed-select path.

Test Plan:
- Reset/idle: assert rst_n=0 mid-stream with out_valid=1 → out_valid=0, out_data=0, out_chan=0, in_ready=0 immediately (async). After release with all in_valid=0, out_valid stays 0.
- Fixed select (N=4, W=16, MODE=0): sel=2, in_valid=4'b0100, ch2=16'hBEEF, out_ready=1 → in_ready=4'b0100. Next cycle out_data=16'hBEEF, out_chan=2, out_valid=1. With sel=3 and in_valid[3]=0 → in_ready=0.
- Out-of-range select (N=3, MODE=0): sel=3, all valid → in_ready=0, out_valid falls to 0 after drain.
- Round robin (N=4, MODE=1): all in_valid=1, ch k=16'h1000+k, out_ready=1 for 8 cycles → out_chan 0,1,2,3,0,1,2,3, one word per cycle, no bubbles.
- Wrap/skip (MODE=1): rr_ptr=3, in_valid=4'b0011 → grants ch0, then ch1, then ch0 (pointer wraps 3→0 and skips invalid channels).
- Backpressure: out_valid=1 holding 16'h00AA, out_ready=0 for 3 cycles with new inputs valid → out_data stays 16'h00AA, in_ready=0, rr_ptr unchanged. When out_ready=1, the pending word loads the same cycle the old one drains.

Source files
------------

// File: rtl/stream_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_mux_pkg
//  Description : Shared constants and helpers for the round-robin / fixed
//                select stream multiplexer.
//  Revision    : 1.0  - initial release
// ============================================================================
package stream_mux_pkg;

    // Selection modes for stream_mux_rr
    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Width of a channel id for n channels; never narrower than one bit.
    function automatic int chan_id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : stream_mux_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Requests are rotated so
//                that channel ptr sits at bit 0, the lowest set bit is
//                isolated, and the one-hot result is rotated back.
//  Revision    : 1.0  - initial release
// ============================================================================
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int N  = 4,
    localparam int SW = chan_id_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [N-1:0] w_rot_req;
    logic [N-1:0] w_rot_gnt;

    // Rotate, priority-pick the lowest requester, rotate back.
    // ptr is always below N, so a right shift of the doubled grant by
    // (N - ptr) undoes the original rotation (ptr = 0 shifts by N).
    always_comb begin
        w_rot_req = N'({req, req} >> ptr);
        w_rot_gnt = w_rot_req & (~w_rot_req + N'(1));
        gnt       = N'({w_rot_gnt, w_rot_gnt} >> (N - int'(ptr)));
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
//  Module      : stream_mux_rr
//  Description : Registered N-channel, W-bit valid/ready stream selector with
//                either an external fixed select or round-robin arbitration.
//                One output register holds the selected word and its source
//                channel; it refills in the same cycle it drains.
//  Revision    : 1.0  - initial release
// ============================================================================
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int W    = 16,
    parameter  int N    = 4,
    parameter  int MODE = MODE_FIXED,
    localparam int SW   = chan_id_width(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_chan,
    output logic           out_valid,
    input  logic           out_ready
);

    logic          w_load;
    logic          w_xfer;
    logic [N-1:0]  w_gnt;
    logic [N-1:0]  w_ready;
    logic [SW-1:0] w_chan_idx;
    logic [W-1:0]  w_sel_data;

    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q,  out_data_d;
    logic [SW-1:0] out_chan_q,  out_chan_d;
    logic [SW-1:0] rr_ptr_q,    rr_ptr_d;

    generate
        if (MODE == MODE_RR) begin : g_rr
            rr_arbiter #(
                .N   (N)
            ) u_arb (
                .req (in_valid),
                .ptr (rr_ptr_q),
                .gnt (w_gnt)
            );
        end else begin : g_fixed
            // Grant the selected channel when it is valid; an out-of-range
            // select matches no channel and therefore grants nothing.
            always_comb begin
                w_gnt = '0;
                for (int k = 0; k < N; k++) begin
                    w_gnt[k] = in_valid[k] && (sel == SW'(k));
                end
            end
        end
    endgenerate

    // Output register may accept a word when empty or draining this cycle;
    // ready is forced low while reset is asserted.
    always_comb begin
        w_load  = !out_valid_q || out_ready;
        w_ready = w_gnt & {N{w_load && rst_n}};
        w_xfer  = |w_ready;
    end

    // One-hot grant to channel index and selected data word.
    always_comb begin
        w_chan_idx = '0;
        w_sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (w_gnt[k]) begin
                w_chan_idx = w_chan_idx | SW'(k);
                w_sel_data = w_sel_data | in_data[k*W +: W];
            end
        end
    end

    // Next state of the output register and the round-robin pointer.
    // The pointer only moves on a transfer so idle cycles keep priority.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        rr_ptr_d    = rr_ptr_q;
        if (w_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = w_sel_data;
            out_chan_d  = w_chan_idx;
            if (MODE == MODE_RR) begin
                rr_ptr_d = (w_chan_idx == SW'(N - 1)) ? '0 : w_chan_idx + SW'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign in_ready  = w_ready;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule : stream_mux_rr
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_mux_rr
//  Description : Self-checking bench for stream_mux_rr: fixed select (N=4),
//                out-of-range select (N=3) and round-robin (N=4).
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_stream_mux_rr;

    logic clk;
    logic rst_n;

    // Fixed-select DUT, N=4
    logic [63:0] f_in_data;
    logic [3:0]  f_in_valid, f_in_ready;
    logic [1:0]  f_sel, f_out_chan;
    logic [15:0] f_out_data;
    logic        f_out_valid, f_out_ready;

    // Fixed-select DUT, N=3
    logic [47:0] t_in_data;
    logic [2:0]  t_in_valid, t_in_ready;
    logic [1:0]  t_sel, t_out_chan;
    logic [15:0] t_out_data;
    logic        t_out_valid, t_out_ready;

    // Round-robin DUT, N=4
    logic [63:0] r_in_data;
    logic [3:0]  r_in_valid, r_in_ready;
    logic [1:0]  r_sel, r_out_chan;
    logic [15:0] r_out_data;
    logic        r_out_valid, r_out_ready;

    int n_checks = 0;
    int n_errors = 0;

    stream_mux_rr #(.W(16), .N(4), .MODE(0)) u_fix (
        .clk(clk), .rst_n(rst_n), .in_data(f_in_data), .in_valid(f_in_valid),
        .in_ready(f_in_ready), .sel(f_sel), .out_data(f_out_data),
        .out_chan(f_out_chan), .out_valid(f_out_valid), .out_ready(f_out_ready));

    stream_mux_rr #(.W(16), .N(3), .MODE(0)) u_fix3 (
        .clk(clk), .rst_n(rst_n), .in_data(t_in_data), .in_valid(t_in_valid),
        .in_ready(t_in_ready), .sel(t_sel), .out_data(t_out_data),
        .out_chan(t_out_chan), .out_valid(t_out_valid), .out_ready(t_out_ready));

    stream_mux_rr #(.W(16), .N(4), .MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_data(r_in_data), .in_valid(r_in_valid),
        .in_ready(r_in_ready), .sel(r_sel), .out_data(r_out_data),
        .out_chan(r_out_chan), .out_valid(r_out_valid), .out_ready(r_out_ready));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [3:0]  valid;
        logic        ordy;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [15:0] exp_od;
        logic [1:0]  exp_oc;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [3:0] e_rdy;
        logic [1:0] e_chan;
        logic [1:0] wrap_exp [3];

        // sel, valid, out_ready | in_ready, out_valid, out_data, out_chan (after edge)
        vecs[0] = '{2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 16'hBEEF, 2'd2};
        vecs[1] = '{2'd3, 4'b0100, 1'b1, 4'b0000, 1'b0, 16'hBEEF, 2'd2};
        vecs[2] = '{2'd0, 4'b1111, 1'b0, 4'b0001, 1'b1, 16'h1111, 2'd0};
        vecs[3] = '{2'd1, 4'b1111, 1'b0, 4'b0000, 1'b1, 16'h1111, 2'd0};
        vecs[4] = '{2'd1, 4'b1111, 1'b1, 4'b0010, 1'b1, 16'h2222, 2'd1};
        vecs[5] = '{2'd3, 4'b1000, 1'b1, 4'b1000, 1'b1, 16'h4444, 2'd3};
        vecs[6] = '{2'd0, 4'b0000, 1'b0, 4'b0000, 1'b1, 16'h4444, 2'd3};
        vecs[7] = '{2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h4444, 2'd3};
        wrap_exp[0] = 2'd0;
        wrap_exp[1] = 2'd1;
        wrap_exp[2] = 2'd0;

        rst_n       = 1'b0;
        f_in_data   = {16'h4444, 16'hBEEF, 16'h2222, 16'h1111};
        f_in_valid  = 4'b0100;
        f_sel       = 2'd2;
        f_out_ready = 1'b1;
        t_in_data   = {16'h3333, 16'h5A5A, 16'h7777};
        t_in_valid  = 3'b000;
        t_sel       = 2'd0;
        t_out_ready = 1'b1;
        r_in_data   = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
        r_in_valid  = 4'b0000;
        r_sel       = 2'd0;
        r_out_ready = 1'b1;

        // Reset state, with a valid granted channel present
        #2;
        check("rst_f_out_valid", 32'(f_out_valid), 32'd0);
        check("rst_f_out_data",  32'(f_out_data),  32'd0);
        check("rst_f_out_chan",  32'(f_out_chan),  32'd0);
        check("rst_f_in_ready",  32'(f_in_ready),  32'd0);
        check("rst_r_out_valid", 32'(r_out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_f_out_valid", 32'(f_out_valid), 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        f_in_valid = 4'b0000;
        @(posedge clk);
        #1;
        check("idle_f_out_valid", 32'(f_out_valid), 32'd0);

        // Fixed select table
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            f_sel       = vecs[i].sel;
            f_in_valid  = vecs[i].valid;
            f_out_ready = vecs[i].ordy;
            #1;
            check($sformatf("fix%0d_in_ready", i), 32'(f_in_ready), 32'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            check($sformatf("fix%0d_out_valid", i), 32'(f_out_valid), 32'(vecs[i].exp_ov));
            check($sformatf("fix%0d_out_data", i),  32'(f_out_data),  32'(vecs[i].exp_od));
            check($sformatf("fix%0d_out_chan", i),  32'(f_out_chan),  32'(vecs[i].exp_oc));
        end

        // Out-of-range select on N=3
        @(negedge clk);
        t_sel      = 2'd1;
        t_in_valid = 3'b111;
        #1;
        check("n3_sel1_in_ready", 32'(t_in_ready), 32'b010);
        @(posedge clk);
        #1;
        check("n3_sel1_out_valid", 32'(t_out_valid), 32'd1);
        check("n3_sel1_out_data",  32'(t_out_data),  32'h5A5A);
        check("n3_sel1_out_chan",  32'(t_out_chan),  32'd1);
        @(negedge clk);
        t_sel = 2'd3;
        #1;
        check("n3_sel3_in_ready", 32'(t_in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("n3_sel3_out_valid", 32'(t_out_valid), 32'd0);
        check("n3_sel3_out_data",  32'(t_out_data),  32'h5A5A);
        @(negedge clk);
        t_in_valid = 3'b000;

        // Round robin, all channels valid: 0,1,2,3,0,1,2,3 with no bubbles
        r_in_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            e_rdy  = 4'b0001 << (i % 4);
            e_chan = 2'(i % 4);
            #1;
            check($sformatf("rr%0d_in_ready", i), 32'(r_in_ready), 32'(e_rdy));
            @(posedge clk);
            #1;
            check($sformatf("rr%0d_out_valid", i), 32'(r_out_valid), 32'd1);
            check($sformatf("rr%0d_out_chan", i),  32'(r_out_chan),  32'(e_chan));
            check($sformatf("rr%0d_out_data", i),  32'(r_out_data),  32'h1000 + 32'(e_chan));
            @(negedge clk);
        end

        // Move pointer to 3, then wrap/skip with only ch0 and ch1 valid
        r_in_valid = 4'b0100;
        #1;
        check("wrap_pre_in_ready", 32'(r_in_ready), 32'b0100);
        @(posedge clk);
        #1;
        check("wrap_pre_out_chan", 32'(r_out_chan), 32'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            r_in_valid = 4'b0011;
            e_rdy      = 4'b0001 << wrap_exp[i];
            #1;
            check($sformatf("wrap%0d_in_ready", i), 32'(r_in_ready), 32'(e_rdy));
            @(posedge clk);
            #1;
            check($sformatf("wrap%0d_out_chan", i), 32'(r_out_chan), 32'(wrap_exp[i]));
        end

        // Pointer now 1: load 16'h00AA from ch0 (search 1,2,3,0)
        @(negedge clk);
        r_in_data[15:0]  = 16'h00AA;
        r_in_data[31:16] = 16'h0BBB;
        r_in_valid       = 4'b0001;
        #1;
        check("bp_load_in_ready", 32'(r_in_ready), 32'b0001);
        @(posedge clk);
        #1;
        check("bp_load_out_data", 32'(r_out_data), 32'h00AA);

        // Backpressure for 3 cycles with all channels valid
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            r_out_ready = 1'b0;
            r_in_valid  = 4'b1111;
            #1;
            check($sformatf("bp%0d_in_ready", i), 32'(r_in_ready), 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("bp%0d_out_data", i),  32'(r_out_data),  32'h00AA);
            check($sformatf("bp%0d_out_valid", i), 32'(r_out_valid), 32'd1);
            check($sformatf("bp%0d_out_chan", i),  32'(r_out_chan),  32'd0);
        end

        // Release: drain and fill in the same cycle; pointer still 1
        @(negedge clk);
        r_out_ready = 1'b1;
        #1;
        check("bp_rel_in_ready", 32'(r_in_ready), 32'b0010);
        @(posedge clk);
        #1;
        check("bp_rel_out_valid", 32'(r_out_valid), 32'd1);
        check("bp_rel_out_data",  32'(r_out_data),  32'h0BBB);
        check("bp_rel_out_chan",  32'(r_out_chan),  32'd1);

        // Idle cycles must not rotate priority (pointer stays 2)
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            r_in_valid = 4'b0000;
            #1;
            check($sformatf("idle%0d_in_ready", i), 32'(r_in_ready), 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("idle%0d_out_valid", i), 32'(r_out_valid), 32'd0);
        end
        @(negedge clk);
        r_in_valid = 4'b1111;
        #1;
        check("idle_after_in_ready", 32'(r_in_ready), 32'b0100);
        @(posedge clk);
        #1;
        check("idle_after_out_chan", 32'(r_out_chan), 32'd2);
        @(negedge clk);
        r_in_valid = 4'b0000;

        // Asynchronous reset mid-stream while a word is held
        f_sel       = 2'd1;
        f_in_valid  = 4'b1111;
        f_out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("mid_pre_out_valid", 32'(f_out_valid), 32'd1);
        check("mid_pre_out_data",  32'(f_out_data),  32'h2222);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(f_out_valid), 32'd0);
        check("mid_rst_out_data",  32'(f_out_data),  32'd0);
        check("mid_rst_out_chan",  32'(f_out_chan),  32'd0);
        check("mid_rst_in_ready",  32'(f_in_ready),  32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        f_in_valid = 4'b0000;
        r_in_valid = 4'b1111;
        #1;
        check("post_rst_rr_in_ready", 32'(r_in_ready), 32'b0001);
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_f_out_valid", 32'(f_out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_stream_mux_rr
`default_nettype wire
